// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply/divide unit with HI/LO registers.
// Optional div_zero flag port enabled by defining MULDIV_DIVZERO_FLAG_EN.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIVZERO_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t state;

    // acc_hi:acc_lo is the product shifter, or remainder:quotient for divide
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             dz;

    logic             idle_like;
    logic             accept;
    logic             move;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // Request decode and operand magnitudes
    always_comb begin
        idle_like = (state == IDLE) || (state == DONE);
        accept    = start && !flush && idle_like && !op[2];
        move      = start && !flush && idle_like && (op[2:1] == 2'b10);
        a_neg     = !op[0] && a[WIDTH-1];
        b_neg     = !op[0] && b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    // The remainder stays below the divisor, so a 1-bit-wider difference
    // gives a correct borrow in bit WIDTH.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        ge      = !diff[WIDTH];
    end

    // Sign fix-up; a zero divisor yields remainder = dividend, quotient = ones
    always_comb begin
        prod   = {acc_hi, acc_lo};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -acc_lo : acc_lo;
        rem_s  = neg_r ? -acc_hi : acc_hi;
        res_hi = is_div ? rem_s : prod_s[2*WIDTH-1:WIDTH];
        res_lo = is_div ? (dz ? '1 : quo_s) : prod_s[WIDTH-1:0];
    end

    // Control FSM, datapath registers and HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (accept) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dz     <= op[1] && (b == '0);
                        acc_hi <= '0;
                        acc_lo <= op[1] ? a_mag : b_mag;
                        opnd   <= op[1] ? b_mag : a_mag;
                    end else if (move) begin
                        if (op[0]) lo <= a;
                        else       hi <= a;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc_hi <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt   <= '0;
                        state <= SIGN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SIGN: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            endcase
        end
    end

`ifdef MULDIV_DIVZERO_FLAG_EN
    // Sticky divide-by-zero flag, raised with done
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            div_zero <= 1'b0;
        end else if (accept) begin
            div_zero <= 1'b0;
        end else if (state == SIGN) begin
            div_zero <= dz;
        end
    end
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed checks of alu_muldiv at WIDTH=32 and WIDTH=8.
// Covers MULTU/MULT/DIV/DIVU, MTHI/MTLO, divide by zero, flush and reset.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, done;
    logic        rst8, start8, flush8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy8, done8;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic        div_zero, div_zero8;
`endif

    int checks = 0;
    int errors = 0;
    int n, nb;
    int seen;
    logic [31:0] hi_prev, lo_prev;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MULDIV_DIVZERO_FLAG_EN
        , .div_zero(div_zero)
`endif
    );

    alu_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .op(op8), .a(a8), .b(b8),
        .flush(flush8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
`ifdef MULDIV_DIVZERO_FLAG_EN
        , .div_zero(div_zero8)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Request on the next edge k; returns at the negedge of cycle k+1
    task automatic start32(input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done; n = cycles after edge k, nb = busy cycles seen
    task automatic wait32(output int cn, output int cb);
        cn = 1; cb = 0;
        while (!done && cn < 100) begin
            if (busy) cb++;
            @(negedge clk);
            cn++;
        end
        if (!done) begin
            errors++;
            $display("FAIL timeout32 observed no done expected done");
        end
    endtask

    task automatic run32(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        start32(o, x, y);
        wait32(n, nb);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        rst8 = 1'b1; start8 = 1'b0; flush8 = 1'b0; op8 = '0;
        a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0; rst8 = 1'b0;

        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
`ifdef MULDIV_DIVZERO_FLAG_EN
        chk("rst_dz", div_zero, 0);
`endif

        // MULTU FFFFFFFF * 2
        run32(3'b001, 32'hFFFF_FFFF, 32'h0000_0002);
        chk("multu_lat", n, 34);
        chk("multu_busy", nb, 33);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // MULT -3 * 5, then MTLO in the DONE cycle
        run32(3'b000, 32'hFFFF_FFFD, 32'h0000_0005);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);
        start = 1'b1; op = 3'b101; a = 32'h1234_5678; b = '0;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h1234_5678);
        chk("mtlo_hi", hi, 32'hFFFF_FFFF);
        chk("mtlo_done", done, 0);
        chk("mtlo_busy", busy, 0);

        // MTHI from IDLE
        start32(3'b100, 32'hCAFE_0001, 32'h0);
        chk("mthi_hi", hi, 32'hCAFE_0001);
        chk("mthi_lo", lo, 32'h1234_5678);

        // op 11x is ignored
        start32(3'b110, 32'h5555_5555, 32'h1);
        chk("ign_busy", busy, 0);
        chk("ign_hi", hi, 32'hCAFE_0001);
        chk("ign_lo", lo, 32'h1234_5678);

        // Signed divides
        run32(3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        run32(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divmin_lo", lo, 32'h8000_0000);
        chk("divmin_hi", hi, 32'h0000_0000);
        run32(3'b011, 32'd100, 32'd7);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        // Divide by zero
        run32(3'b011, 32'h0000_0007, 32'h0000_0000);
        chk("dz_lat", n, 34);
        chk("dz_hi", hi, 32'h0000_0007);
        chk("dz_lo", lo, 32'hFFFF_FFFF);
`ifdef MULDIV_DIVZERO_FLAG_EN
        chk("dz_flag_done", div_zero, 1);
        repeat (3) @(negedge clk);
        chk("dz_flag_hold", div_zero, 1);
`endif
        run32(3'b010, 32'hFFFF_FFF9, 32'h0000_0000);
        chk("sdz_hi", hi, 32'hFFFF_FFF9);
        chk("sdz_lo", lo, 32'hFFFF_FFFF);
`ifdef MULDIV_DIVZERO_FLAG_EN
        start32(3'b001, 32'd3, 32'd4);
        chk("dz_flag_clr", div_zero, 0);
        wait32(n, nb);
`else
        run32(3'b001, 32'd3, 32'd4);
`endif
        chk("mul34_lo", lo, 32'd12);
        chk("mul34_hi", hi, 32'd0);

        // Flush in CALC cycle 10 with an ignored request at cycle 5
        hi_prev = hi; lo_prev = lo;
        start32(3'b001, 32'h0000_1234, 32'h0000_0010);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        chk("fl_busy5", busy, 1);
        chk("fl_hi5", hi, hi_prev);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_busy", busy, 0);
        chk("fl_done", done, 0);
        seen = 0;
        repeat (40) begin
            if (done || busy) seen++;
            @(negedge clk);
        end
        chk("fl_quiet", seen, 0);
        chk("fl_hi", hi, hi_prev);
        chk("fl_lo", lo, lo_prev);

        // WIDTH=8 DIVU 200 / 7
        @(negedge clk);
        start8 = 1'b1; op8 = 3'b011; a8 = 8'hC8; b8 = 8'h07;
        @(negedge clk);
        start8 = 1'b0;
        n = 1; nb = 0;
        while (!done8 && n < 100) begin
            if (busy8) nb++;
            @(negedge clk);
            n++;
        end
        chk("w8_lat", n, 10);
        chk("w8_busy", nb, 9);
        chk("w8_lo", lo8, 8'h1C);
        chk("w8_hi", hi8, 8'h04);

        // WIDTH=8 reset mid-CALC
        start8 = 1'b1; op8 = 3'b001; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("w8_busy_mid", busy8, 1);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        chk("w8_rst_hi", hi8, 0);
        chk("w8_rst_lo", lo8, 0);
        chk("w8_rst_busy", busy8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
